// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_pkg
// Purpose  : Shared response codes, channel FSM states and sizing helper
//            for the AXI4-Lite multi-port slave.
// Revision : 1.0
// ============================================================================
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        WAIT     = 2'd2,
        RESP     = 2'd3
    } chan_state_t;

    // Port-index width; a single port still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_if
// Purpose  : AXI4-Lite bundle (AW, W, B, AR, R) with master/slave modports.
// Revision : 1.0
// ============================================================================
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic ACLK
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_addr_decode
// Purpose  : Combinational address map: {mapped, port index, local offset}.
// Revision : 1.0
// ============================================================================
module axi4_lite_addr_decode
    import axi4_lite_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH  = 32,
    parameter int                       NUM_PORTS      = 4,
    parameter int                       PORT_ADDR_BITS = 12,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                       IDX_W          = idx_width(NUM_PORTS)
) (
    input  logic [ADDRESS_WIDTH-1:0]  i_addr,
    output logic                      o_mapped,
    output logic [IDX_W-1:0]          o_idx,
    output logic [PORT_ADDR_BITS-1:0] o_offset
);
    logic [ADDRESS_WIDTH:0]   w_diff;
    logic [ADDRESS_WIDTH-1:0] w_idx_full;

    // The extra MSB is the borrow: set when the address lies below the base.
    assign w_diff     = {1'b0, i_addr} - {1'b0, BASE_ADDR};
    assign w_idx_full = w_diff[ADDRESS_WIDTH-1:0] >> PORT_ADDR_BITS;
    assign o_mapped   = !w_diff[ADDRESS_WIDTH] && (w_idx_full < ADDRESS_WIDTH'(NUM_PORTS));
    assign o_idx      = w_idx_full[IDX_W-1:0];
    assign o_offset   = i_addr[PORT_ADDR_BITS-1:0];
endmodule
`default_nettype wire

// File: rtl/axi4_lite_slave_nport.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_nport
// Purpose  : AXI4-Lite slave fanning out to NUM_PORTS request/done ports,
//            independent read and write FSMs. AXIL_SLV_TIMEOUT_EN adds a
//            WAIT-state timeout answering SLVERR.
// Revision : 1.0
// ============================================================================
module axi4_lite_slave_nport
    import axi4_lite_pkg::*;
#(
    parameter int                       DATA_WIDTH     = 32,
    parameter int                       ADDRESS_WIDTH  = 32,
    parameter int                       NUM_PORTS      = 4,
    parameter int                       PORT_ADDR_BITS = 12,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                       TIMEOUT_CYCLES = 256
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    axi_lite_if.slave                        axi,
    output logic [PORT_ADDR_BITS-1:0]        per_waddr,
    output logic [DATA_WIDTH-1:0]            per_wdata,
    output logic [DATA_WIDTH/8-1:0]          per_wstrb,
    output logic [NUM_PORTS-1:0]             per_write,
    input  logic [NUM_PORTS-1:0]             per_write_done,
    input  logic [NUM_PORTS*2-1:0]           per_bresp,
    output logic [PORT_ADDR_BITS-1:0]        per_raddr,
    output logic [NUM_PORTS-1:0]             per_read,
    input  logic [NUM_PORTS-1:0]             per_read_done,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  per_rdata,
    input  logic [NUM_PORTS*2-1:0]           per_rresp
);
    localparam int IDX_W = idx_width(NUM_PORTS);

    if (NUM_PORTS < 1 || NUM_PORTS > 16) begin : g_bad_num_ports
        $error("NUM_PORTS must be 1..16");
    end
    if (TIMEOUT_CYCLES < 1 || DATA_WIDTH % 8 != 0) begin : g_bad_params
        $error("TIMEOUT_CYCLES must be >= 1 and DATA_WIDTH a multiple of 8");
    end

    // ---------------- write channel ----------------
    chan_state_t              r_wr_state, w_wr_next;
    logic                     r_awready, r_wready, r_aw_done, r_w_done;
    logic [ADDRESS_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH/8-1:0]  r_wstrb;
    resp_t                    r_bresp;
    logic                     w_wr_mapped, w_aw_hs, w_w_hs, w_wr_done, w_wr_expired;
    logic [IDX_W-1:0]         w_wr_idx;

    axi4_lite_addr_decode #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH), .NUM_PORTS(NUM_PORTS),
        .PORT_ADDR_BITS(PORT_ADDR_BITS), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
    ) u_wr_dec (
        .i_addr(r_awaddr), .o_mapped(w_wr_mapped), .o_idx(w_wr_idx), .o_offset(per_waddr)
    );

    assign w_aw_hs   = axi.AWVALID && r_awready;
    assign w_w_hs    = axi.WVALID && r_wready;
    assign w_wr_done = per_write_done[w_wr_idx];

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            IDLE:     if (r_aw_done && r_w_done) w_wr_next = DISPATCH;
            DISPATCH: w_wr_next = w_wr_mapped ? WAIT : RESP;
            WAIT:     if (w_wr_done || w_wr_expired) w_wr_next = RESP;
            RESP:     if (axi.BREADY) w_wr_next = IDLE;
            default:  w_wr_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_state <= IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= OKAY;
        end else begin
            r_wr_state <= w_wr_next;
            // Capture flags live only while IDLE; READY drops after its own handshake.
            r_aw_done  <= (w_wr_next == IDLE) && (r_aw_done || w_aw_hs);
            r_w_done   <= (w_wr_next == IDLE) && (r_w_done || w_w_hs);
            r_awready  <= (w_wr_next == IDLE) && !(r_aw_done || w_aw_hs);
            r_wready   <= (w_wr_next == IDLE) && !(r_w_done || w_w_hs);
            if (w_aw_hs) r_awaddr <= axi.AWADDR;
            if (w_w_hs) begin
                r_wdata <= axi.WDATA;
                r_wstrb <= axi.WSTRB;
            end
            if (r_wr_state == DISPATCH && !w_wr_mapped) begin
                r_bresp <= DECERR;
            end else if (r_wr_state == WAIT) begin
                if (w_wr_done)         r_bresp <= resp_t'(per_bresp[{w_wr_idx, 1'b0} +: 2]);
                else if (w_wr_expired) r_bresp <= SLVERR;
            end
        end
    end

    assign per_wdata   = r_wdata;
    assign per_wstrb   = r_wstrb;
    assign per_write   = (r_wr_state == DISPATCH && w_wr_mapped) ? (NUM_PORTS'(1) << w_wr_idx) : '0;
    assign axi.AWREADY = r_awready;
    assign axi.WREADY  = r_wready;
    assign axi.BVALID  = (r_wr_state == RESP);
    assign axi.BRESP   = r_bresp;

    // ---------------- read channel ----------------
    chan_state_t              r_rd_state, w_rd_next;
    logic                     r_arready, r_ar_done;
    logic [ADDRESS_WIDTH-1:0] r_araddr;
    logic [DATA_WIDTH-1:0]    r_rdata;
    resp_t                    r_rresp;
    logic                     w_rd_mapped, w_ar_hs, w_rd_done, w_rd_expired;
    logic [IDX_W-1:0]         w_rd_idx;

    axi4_lite_addr_decode #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH), .NUM_PORTS(NUM_PORTS),
        .PORT_ADDR_BITS(PORT_ADDR_BITS), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
    ) u_rd_dec (
        .i_addr(r_araddr), .o_mapped(w_rd_mapped), .o_idx(w_rd_idx), .o_offset(per_raddr)
    );

    assign w_ar_hs   = axi.ARVALID && r_arready;
    assign w_rd_done = per_read_done[w_rd_idx];

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            IDLE:     if (r_ar_done) w_rd_next = DISPATCH;
            DISPATCH: w_rd_next = w_rd_mapped ? WAIT : RESP;
            WAIT:     if (w_rd_done || w_rd_expired) w_rd_next = RESP;
            RESP:     if (axi.RREADY) w_rd_next = IDLE;
            default:  w_rd_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rd_state <= IDLE;
            r_arready  <= 1'b0;
            r_ar_done  <= 1'b0;
            r_araddr   <= '0;
            r_rdata    <= '0;
            r_rresp    <= OKAY;
        end else begin
            r_rd_state <= w_rd_next;
            r_ar_done  <= (w_rd_next == IDLE) && (r_ar_done || w_ar_hs);
            r_arready  <= (w_rd_next == IDLE) && !(r_ar_done || w_ar_hs);
            if (w_ar_hs) r_araddr <= axi.ARADDR;
            if (r_rd_state == DISPATCH && !w_rd_mapped) begin
                r_rdata <= '0;
                r_rresp <= DECERR;
            end else if (r_rd_state == WAIT) begin
                if (w_rd_done) begin
                    r_rdata <= per_rdata[int'(w_rd_idx) * DATA_WIDTH +: DATA_WIDTH];
                    r_rresp <= resp_t'(per_rresp[{w_rd_idx, 1'b0} +: 2]);
                end else if (w_rd_expired) begin
                    r_rdata <= '0;
                    r_rresp <= SLVERR;
                end
            end
        end
    end

    assign per_read    = (r_rd_state == DISPATCH && w_rd_mapped) ? (NUM_PORTS'(1) << w_rd_idx) : '0;
    assign axi.ARREADY = r_arready;
    assign axi.RVALID  = (r_rd_state == RESP);
    assign axi.RDATA   = r_rdata;
    assign axi.RRESP   = r_rresp;

    // ---------------- optional WAIT timeout ----------------
`ifdef AXIL_SLV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wr_cnt, r_rd_cnt;

    assign w_wr_expired = (r_wr_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign w_rd_expired = (r_rd_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (r_wr_state != WAIT)  r_wr_cnt <= '0;
            else if (!w_wr_expired)  r_wr_cnt <= r_wr_cnt + 1'b1;
            if (r_rd_state != WAIT)  r_rd_cnt <= '0;
            else if (!w_rd_expired)  r_rd_cnt <= r_rd_cnt + 1'b1;
        end
    end
`else
    assign w_wr_expired = 1'b0;
    assign w_rd_expired = 1'b0;
`endif

endmodule
`default_nettype wire
